// File: rtl/ip_uart_tx_fifo_pkg.sv
// Shared constants and types for the UART TX byte FIFO: I/O port map,
// status register layout and drain FSM states.
package ip_uart_tx_fifo_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEVEL_W = 5;

  localparam logic [ADDR_W-1:0] DATA_PORT_DEF = 8'h10;
  localparam logic [ADDR_W-1:0] STAT_PORT_DEF = 8'h11;

  // Status register bit positions
  localparam int unsigned ST_FULL      = 7;
  localparam int unsigned ST_EMPTY     = 6;
  localparam int unsigned ST_ACTIVE    = 5;
  localparam int unsigned ST_LEVEL_MSB = 4;
  localparam int unsigned ST_LEVEL_LSB = 0;

  localparam int unsigned CTRL_FLUSH = 0;

  typedef struct packed {
    logic               full;
    logic               empty;
    logic               active;
    logic [LEVEL_W-1:0] level;
  } status_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ip_uart_sync_fifo.sv
// Single-clock FIFO with level tracking and a synchronous flush.
// Flush wins over a coincident push or pop.
module ip_uart_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ip_uart_tx_fifo.sv
// UART TX byte FIFO: I/O bus decode, status read register and the FSM that
// drains queued bytes into the ip_uart serialiser over send_data/req/busy.
module ip_uart_tx_fifo
  import ip_uart_tx_fifo_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 4,
  parameter logic [ADDR_W-1:0] DATA_PORT  = DATA_PORT_DEF,
  parameter logic [ADDR_W-1:0] STAT_PORT  = STAT_PORT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic              bus_ioreq,
  input  logic              bus_write,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rdata_en,
  output logic [DATA_W-1:0] send_data,
  output logic              send_req,
  input  logic              send_busy
);

  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic              dec_d, dec_s;
  logic              push, stat_rd, flush;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  status_t           status;

  tx_state_e         state_q, state_d;
  logic              send_req_q, send_req_d;
  logic [DATA_W-1:0] send_data_q, send_data_d;
  logic              rdata_en_q, rdata_en_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign dec_d = bus_ioreq & (bus_address == DATA_PORT);
  assign dec_s = bus_ioreq & (bus_address == STAT_PORT);

  // Data-port reads are never accepted; writes stall while full.
  assign bus_ready = (dec_d & bus_write & ~fifo_full) | dec_s;
  assign push      = dec_d & bus_write & bus_valid & ~fifo_full;
  assign stat_rd   = dec_s & ~bus_write & bus_valid;
  assign flush     = dec_s & bus_write & bus_valid & bus_wdata[CTRL_FLUSH];

  ip_uart_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus_wdata),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status        = '0;
    status.full   = fifo_full;
    status.empty  = fifo_empty;
    status.active = (state_q != TX_IDLE);
    status.level  = LEVEL_W'(fifo_level);
  end

  always_comb begin
    rdata_en_d = stat_rd;
    rdata_d    = '0;
    if (stat_rd) rdata_d = status;
  end

  // Drain FSM; a flush in the same cycle blocks the pop so no flushed byte leaks.
  always_comb begin
    state_d     = state_q;
    send_req_d  = 1'b0;
    send_data_d = send_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (~fifo_empty & ~send_busy & ~flush) begin
          fifo_pop    = 1'b1;
          send_data_d = fifo_rdata;
          state_d     = TX_REQ;
        end
      end
      TX_REQ: begin
        if (send_busy) state_d = TX_WAIT;
        else           send_req_d = 1'b1;
      end
      TX_WAIT: begin
        if (~send_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      send_req_q  <= 1'b0;
      send_data_q <= '0;
      rdata_en_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      send_req_q  <= send_req_d;
      send_data_q <= send_data_d;
      rdata_en_q  <= rdata_en_d;
      rdata_q     <= rdata_d;
    end
  end

  assign send_req     = send_req_q;
  assign send_data    = send_data_q;
  assign bus_rdata_en = rdata_en_q;
  assign bus_rdata    = rdata_q;

endmodule

// File: tb/tb_ip_uart_tx_fifo.sv
// Bench for ip_uart_tx_fifo: bus master tasks, a simple ip_uart model and a
// byte scoreboard checking transmitted order.
module tb_ip_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus_address = '0;
  logic       bus_ioreq = 1'b0;
  logic       bus_write = 1'b0;
  logic       bus_valid = 1'b0;
  logic       bus_ready;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;
  logic [7:0] send_data;
  logic       send_req;
  logic       send_busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         busy_cnt = 0;
  int         frame = 4;
  logic       hold_busy = 1'b0;
  logic       accept_en = 1'b1;

  always #5 clk = ~clk;

  ip_uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_address  (bus_address),
    .bus_ioreq    (bus_ioreq),
    .bus_write    (bus_write),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rdata_en (bus_rdata_en),
    .send_data    (send_data),
    .send_req     (send_req),
    .send_busy    (send_busy)
  );

  // ip_uart model: takes a byte on send_req, then stays busy for 'frame' clocks
  assign send_busy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (send_req && !hold_busy && accept_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL uart_rx unexpected byte got=%02h expected none", send_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (send_data !== exp_b) begin
          n_err++;
          $display("FAIL uart_rx order got=%02h expected=%02h", send_data, exp_b);
        end
      end
      busy_cnt <= frame;
    end
  end

  task automatic bus_wr(input logic [7:0] addr, input logic [7:0] data, input int max_wait);
    int n = 0;
    @(negedge clk);
    bus_address = addr; bus_ioreq = 1'b1; bus_write = 1'b1; bus_valid = 1'b1; bus_wdata = data;
    #1;
    while (!bus_ready && n < max_wait) begin
      @(negedge clk); #1; n++;
    end
    if (bus_ready) begin
      @(posedge clk);
      if (addr == 8'h10) exp_q.push_back(data);
    end else begin
      n_cmp++; n_err++;
      $display("FAIL bus_wr_timeout addr=%02h data=%02h ready=%0b expected 1", addr, data, bus_ready);
    end
    #1;
    bus_valid = 1'b0; bus_ioreq = 1'b0; bus_write = 1'b0;
  endtask

  task automatic stat_rd(output logic [7:0] val, output logic en);
    @(negedge clk);
    bus_address = 8'h11; bus_ioreq = 1'b1; bus_write = 1'b0; bus_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_valid = 1'b0; bus_ioreq = 1'b0;
    en  = bus_rdata_en;
    val = bus_rdata;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || send_busy || send_req) && n < max_cyc) begin
      @(negedge clk); n++;
    end
    if (n >= max_cyc) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout left=%0d expected 0", exp_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v; logic e;
    #12;
    n_cmp += 4;
    if (send_req !== 1'b0)     begin n_err++; $display("FAIL rst_send_req got=%b exp=0", send_req); end
    if (send_data !== 8'h00)   begin n_err++; $display("FAIL rst_send_data got=%02h exp=00", send_data); end
    if (bus_rdata_en !== 1'b0) begin n_err++; $display("FAIL rst_rdata_en got=%b exp=0", bus_rdata_en); end
    if (bus_rdata !== 8'h00)   begin n_err++; $display("FAIL rst_rdata got=%02h exp=00", bus_rdata); end
    @(negedge clk); reset = 1'b0;
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h40) begin n_err++; $display("FAIL rst_status got=%02h en=%b exp=40", v, e); end
    // Queue three bytes with the UART refusing, then reset mid-request
    accept_en = 1'b0;
    bus_wr(8'h10, 8'hA1, 20);
    bus_wr(8'h10, 8'hA2, 20);
    bus_wr(8'h10, 8'hA3, 20);
    n_cmp++;
    if (send_req !== 1'b1) begin n_err++; $display("FAIL midxfer_req got=%b exp=1", send_req); end
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h22) begin n_err++; $display("FAIL midxfer_status got=%02h en=%b exp=22", v, e); end
    #1 reset = 1'b1;
    #1;
    n_cmp += 3;
    if (send_req !== 1'b0)     begin n_err++; $display("FAIL async_rst_req got=%b exp=0", send_req); end
    if (bus_rdata_en !== 1'b0) begin n_err++; $display("FAIL async_rst_rdata_en got=%b exp=0", bus_rdata_en); end
    if (send_data !== 8'h00)   begin n_err++; $display("FAIL async_rst_data got=%02h exp=00", send_data); end
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    accept_en = 1'b1;
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h40) begin n_err++; $display("FAIL post_rst_status got=%02h en=%b exp=40", v, e); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (send_req !== 1'b0) begin n_err++; $display("FAIL post_rst_idle_req got=%b exp=0", send_req); end
  endtask

  task automatic test_single();
    frame = 4;
    bus_wr(8'h10, 8'h55, 20);
    @(posedge clk); #1;
    n_cmp++;
    if (send_req !== 1'b0) begin n_err++; $display("FAIL single_req_p1 got=%b exp=0", send_req); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (send_req !== 1'b1)   begin n_err++; $display("FAIL single_req_p2 got=%b exp=1", send_req); end
    if (send_data !== 8'h55) begin n_err++; $display("FAIL single_data got=%02h exp=55", send_data); end
    @(posedge clk); #1;
    n_cmp++;
    if (send_req !== 1'b1) begin n_err++; $display("FAIL single_req_p3 got=%b exp=1", send_req); end
    @(posedge clk); #1;
    n_cmp++;
    if (send_req !== 1'b0 || send_busy !== 1'b1)
      begin n_err++; $display("FAIL single_req_drop req=%b busy=%b exp req=0 busy=1", send_req, send_busy); end
    drain(200);
  endtask

  task automatic test_burst_full();
    logic [7:0] v; logic e; int n;
    frame = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) bus_wr(8'h10, 8'(i), 5);
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h90) begin n_err++; $display("FAIL full_status got=%02h en=%b exp=90", v, e); end
    @(negedge clk);
    bus_address = 8'h10; bus_ioreq = 1'b1; bus_write = 1'b1; bus_valid = 1'b1; bus_wdata = 8'h10;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus_ready !== 1'b0) begin n_err++; $display("FAIL full_stall cyc=%0d ready=%b exp=0", k, bus_ready); end
      @(negedge clk); #1;
    end
    hold_busy = 1'b0;
    n = 0;
    while (!bus_ready && n < 10) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (bus_ready !== 1'b1) begin n_err++; $display("FAIL full_release ready=%b exp=1", bus_ready); end
    @(posedge clk);
    if (bus_ready === 1'b1) exp_q.push_back(8'h10);
    #1;
    bus_valid = 1'b0; bus_ioreq = 1'b0; bus_write = 1'b0;
    drain(2000);
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h40) begin n_err++; $display("FAIL burst_end_status got=%02h en=%b exp=40", v, e); end
  endtask

  task automatic test_wrap();
    logic [7:0] v; logic e; int n;
    frame = 10;
    for (int i = 0; i < 4; i++) bus_wr(8'h10, 8'(8'h80 + i), 20);
    for (int i = 0; i < 40; i++) begin
      n = 0;
      @(negedge clk);
      while (!send_busy && n < 50) begin @(negedge clk); n++; end
      while (send_busy && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin n_cmp++; n_err++; $display("FAIL wrap_wait_timeout iter=%0d", i); end
      bus_wr(8'h10, 8'(8'hA0 + i), 5);
      stat_rd(v, e);
      n_cmp++;
      if (e !== 1'b1 || v !== 8'h23) begin n_err++; $display("FAIL wrap_level iter=%0d got=%02h en=%b exp=23", i, v, e); end
    end
    drain(3000);
  endtask

  task automatic test_flush();
    logic [7:0] v; logic e;
    frame = 5;
    accept_en = 1'b0;
    for (int i = 0; i < 5; i++) bus_wr(8'h10, 8'(8'hC0 + i), 20);
    bus_wr(8'h11, 8'h01, 5);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    stat_rd(v, e);
    n_cmp += 3;
    if (e !== 1'b1 || v !== 8'h60) begin n_err++; $display("FAIL flush_status got=%02h en=%b exp=60", v, e); end
    if (send_req !== 1'b1)   begin n_err++; $display("FAIL flush_req_kept got=%b exp=1", send_req); end
    if (send_data !== 8'hC0) begin n_err++; $display("FAIL flush_data_kept got=%02h exp=c0", send_data); end
    accept_en = 1'b1;
    drain(500);
    stat_rd(v, e);
    n_cmp++;
    if (e !== 1'b1 || v !== 8'h40) begin n_err++; $display("FAIL flush_end_status got=%02h en=%b exp=40", v, e); end
  endtask

  task automatic test_status_b2b();
    frame = 30;
    bus_wr(8'h10, 8'hD0, 20);
    bus_wr(8'h10, 8'hD1, 20);
    bus_wr(8'h10, 8'hD2, 20);
    n_cmp++;
    if (bus_rdata_en !== 1'b0 || bus_rdata !== 8'h00)
      begin n_err++; $display("FAIL b2b_pre en=%b rdata=%02h exp en=0 rdata=00", bus_rdata_en, bus_rdata); end
    @(negedge clk);
    bus_address = 8'h11; bus_ioreq = 1'b1; bus_write = 1'b0; bus_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus_rdata_en !== 1'b1 || bus_rdata !== 8'h22)
      begin n_err++; $display("FAIL b2b_first en=%b rdata=%02h exp en=1 rdata=22", bus_rdata_en, bus_rdata); end
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_ioreq = 1'b0;
    n_cmp++;
    if (bus_rdata_en !== 1'b1 || bus_rdata !== 8'h22)
      begin n_err++; $display("FAIL b2b_second en=%b rdata=%02h exp en=1 rdata=22", bus_rdata_en, bus_rdata); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus_rdata_en !== 1'b0 || bus_rdata !== 8'h00)
      begin n_err++; $display("FAIL b2b_after en=%b rdata=%02h exp en=0 rdata=00", bus_rdata_en, bus_rdata); end
    drain(500);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_full();
    test_wrap();
    test_flush();
    test_status_b2b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
